// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative restoring DIV/DIVU, RADIX_LOG2 quotient bits per cycle; MULDIV_EARLY_TERM_EN enables LZC skip.
// Latency: done at T+N+1 (divisor 0: T+1; early-term build: variable, min T+2).
// Backpressure: hold keeps the result in DONE; stallreq freezes IF..EX while a divide is pending.
module ex_div_unit #(
  parameter int WIDTH      = 32,
  parameter int RADIX_LOG2 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stallreq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int N  = WIDTH / RADIX_LOG2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             dvs_zero;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] quo_init;
  logic [CW-1:0]    cnt_init;

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q_q, neg_r_q;
  logic [WIDTH-1:0] quo_step, rem_step;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign accept   = (state == S_IDLE) & start & ~flush;
  assign dvs_zero = (divisor == '0);
  assign a_abs    = (op_signed & dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
  assign b_abs    = (op_signed & divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

`ifdef MULDIV_EARLY_TERM_EN
  localparam int LW = $clog2(WIDTH + 1);

  function automatic logic [LW-1:0] lzc_f(input logic [WIDTH-1:0] v);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) found = 1'b1;
      else if (!found) n = n + 1;
    end
    return LW'(n);
  endfunction

  logic [LW-1:0] pre_shift;

  // Skip whole groups of leading zeros so the remaining bit count stays a multiple of RADIX_LOG2
  always_comb begin
    int skip;
    skip      = int'(lzc_f(a_abs)) / RADIX_LOG2;
    pre_shift = LW'(skip * RADIX_LOG2);
    cnt_init  = (skip >= N) ? CW'(1) : CW'(N - skip);
    quo_init  = a_abs << pre_shift;
  end
`else
  assign cnt_init = CW'(N);
  assign quo_init = a_abs;
`endif

  // Restoring steps: dividend bits shift out of quo_q's top while quotient bits shift into its bottom
  always_comb begin
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] rem_v, quo_v;
    sh    = '0;
    rem_v = rem_q;
    quo_v = quo_q;
    for (int i = 0; i < RADIX_LOG2; i++) begin
      sh    = {rem_v, quo_v[WIDTH-1]};
      quo_v = {quo_v[WIDTH-2:0], 1'b0};
      if (sh >= {1'b0, dvs_q}) begin
        sh       = sh - {1'b0, dvs_q};
        quo_v[0] = 1'b1;
      end
      rem_v = sh[WIDTH-1:0];
    end
    rem_step = rem_v;
    quo_step = quo_v;
  end

  assign q_fix = neg_q_q ? (~quo_step + 1'b1) : quo_step;
  assign r_fix = neg_r_q ? (~rem_step + 1'b1) : rem_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = dvs_zero ? S_DONE : S_RUN;
      S_RUN: begin
        if (flush)                  state_nxt = S_IDLE;
        else if (cnt_q == CW'(1))   state_nxt = S_DONE;
      end
      S_DONE: if (flush || !hold) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stallreq = accept | ((state == S_RUN) & ~flush);
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      quo_q   <= quo_init;
      rem_q   <= '0;
      dvs_q   <= b_abs;
      cnt_q   <= cnt_init;
      neg_q_q <= op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r_q <= op_signed & dividend[WIDTH-1];
      if (dvs_zero) begin
        quotient  <= '1;
        remainder <= dividend;
        div_zero  <= 1'b1;
      end else begin
        div_zero  <= 1'b0;
      end
    end else if (state == S_RUN && !flush) begin
      quo_q <= quo_step;
      rem_q <= rem_step;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        quotient  <= q_fix;
        remainder <= r_fix;
        div_zero  <= 1'b0;
      end
    end
  end

endmodule
